// File: rtl/gst_sched_pkg.sv
// Shared scheduler definitions: FSM state encoding, recovery-counter width, clog2 helper.
package gst_sched_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WRITE   = 2'd1;
   localparam logic [1:0] ST_RECOVER = 2'd2;

   // Holds GAP values 0..15
   localparam int GAP_W = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/reg_write_sched_if.sv
// Requester strobe bundle and register-bank write port of reg_write_sched.
interface reg_write_sched_if #(
   parameter int NREQ = 4,
   parameter int AW   = 6,
   parameter int DW   = 16
);
   import gst_sched_pkg::*;

   localparam int SW = clog2(NREQ);

   logic [NREQ-1:0]    req_stb;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_pend;
   logic [NREQ-1:0]    req_ovr;
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [DW-1:0]      wr_data;
   logic [SW-1:0]      wr_src;
   logic               busy;

   modport master (
      output req_stb, req_addr, req_data,
      input  req_pend, req_ovr, wr_en, wr_addr, wr_data, wr_src, busy
   );

   modport slave (
      input  req_stb, req_addr, req_data,
      output req_pend, req_ovr, wr_en, wr_addr, wr_data, wr_src, busy
   );

endinterface

// File: rtl/reg_write_sched_strobe_capture.sv
// strobe_capture: samples one async write strobe, edge-detects it and holds addr/data in a pending slot.
// Latency: slot pending one edge after the sampled rise (+2 edges with SYNC2_EN defined).
// Backpressure: none; a new rise on an unserved slot overwrites it and sets the sticky overrun flag.
module strobe_capture
   import gst_sched_pkg::*;
#(
   parameter int AW = 6,
   parameter int DW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          stb,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data,
   input  logic          grant,
   output logic          pend,
   output logic          ovr,
   output logic [AW-1:0] slot_addr,
   output logic [DW-1:0] slot_data
);

   logic stb_s;
   logic hist;
   logic rise;

`ifdef SYNC2_EN
   logic [1:0] sync;

   always_ff @(posedge clock) begin
      if (reset) sync <= 2'b11;
      else       sync <= {sync[0], stb};
   end

   assign stb_s = sync[1];
`else
   assign stb_s = stb;
`endif

   // History resets high so a strobe held through reset is not a rise
   assign rise = stb_s & ~hist;

   always_ff @(posedge clock) begin
      if (reset) begin
         hist      <= 1'b1;
         pend      <= 1'b0;
         ovr       <= 1'b0;
         slot_addr <= '0;
         slot_data <= '0;
      end else begin
         hist <= stb_s;
         if (rise) begin
            pend      <= 1'b1;
            slot_addr <= addr;
            slot_data <= data;
            if (pend && !grant) ovr <= 1'b1;
         end else if (grant) begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/reg_write_sched.sv
// reg_write_sched: round-robin sharing of one register-bank write port among NREQ strobed requesters (SYNC2_EN adds 2-flop strobe sync).
// Latency: capture edge k -> wr_en high after edge k+1; one write per GAP+2 cycles in steady state.
// Backpressure: none toward sources; unserved slots are overwritten and flagged in req_ovr.
module reg_write_sched
   import gst_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = 6,
   parameter int DW   = 16,
   parameter int GAP  = 1
) (
   input logic            clock,
   input logic            reset,
   reg_write_sched_if.slave bus
);

   localparam int SW = clog2(NREQ);

   logic [NREQ-1:0]  pend;
   logic [NREQ-1:0]  ovr;
   logic [NREQ-1:0]  grant;
   logic [AW-1:0]    slot_addr [NREQ];
   logic [DW-1:0]    slot_data [NREQ];
   logic [1:0]       state;
   logic [GAP_W-1:0] gap_cnt;
   logic [SW-1:0]    ptr;
   logic [SW-1:0]    win;
   logic [SW:0]      idx;
   logic             found;

   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_req
         strobe_capture #(.AW(AW), .DW(DW)) u_cap (
            .clock     (clock),
            .reset     (reset),
            .stb       (bus.req_stb[i]),
            .addr      (bus.req_addr[i*AW +: AW]),
            .data      (bus.req_data[i*DW +: DW]),
            .grant     (grant[i]),
            .pend      (pend[i]),
            .ovr       (ovr[i]),
            .slot_addr (slot_addr[i]),
            .slot_data (slot_data[i])
         );
      end
   endgenerate

   // Scan from the slot after the last winner, wrapping; the last winner is checked last
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = '0;
      grant = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = {1'b0, ptr} + (SW+1)'(k);
         if (idx >= (SW+1)'(NREQ)) idx = idx - (SW+1)'(NREQ);
         if (!found && pend[idx[SW-1:0]]) begin
            found = 1'b1;
            win   = idx[SW-1:0];
         end
      end
      if (state == ST_IDLE && found) grant[win] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         gap_cnt     <= '0;
         ptr         <= SW'(NREQ - 1);
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         bus.wr_src  <= '0;
      end else begin
         bus.wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (found) begin
                  state       <= ST_WRITE;
                  bus.wr_en   <= 1'b1;
                  bus.wr_addr <= slot_addr[win];
                  bus.wr_data <= slot_data[win];
                  bus.wr_src  <= win;
                  ptr         <= win;
               end
            end
            ST_WRITE: begin
               if (GAP > 0) begin
                  state   <= ST_RECOVER;
                  gap_cnt <= GAP_W'(GAP - 1);
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RECOVER: begin
               if (gap_cnt == '0) state <= ST_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_pend = pend;
   assign bus.req_ovr  = ovr;
   assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_reg_write_sched.sv
// Self-checking bench for reg_write_sched: directed scenarios plus random strobes against a time-budget model.
module tb_reg_write_sched;
   import gst_sched_pkg::*;

   localparam int NREQ = 4;
   localparam int AW   = 6;
   localparam int DW   = 16;
   localparam int GAP  = 1;
   localparam int SW   = clog2(NREQ);
`ifdef SYNC2_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;

   reg_write_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   reg_write_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .GAP(GAP)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: strobe seen SD edges late; after a grant the port is unavailable for GAP+1 edges
   bit            m_live = 1'b0;
   bit            m_pipe0 [NREQ];
   bit            m_pipe1 [NREQ];
   bit            m_hist  [NREQ];
   bit            m_pend  [NREQ];
   bit            m_ovr   [NREQ];
   logic [AW-1:0] m_addr  [NREQ];
   logic [DW-1:0] m_data  [NREQ];
   int            m_ptr, m_wait;
   bit            m_wr_en;
   logic [AW-1:0] m_wr_addr;
   logic [DW-1:0] m_wr_data;
   int            m_wr_src;

   always @(posedge clock) begin
      bit s [NREQ];
      int win;
      cyc++;
      m_live = 1'b1;
      if (reset) begin
         for (int i = 0; i < NREQ; i++) begin
            m_pipe0[i] = 1'b1; m_pipe1[i] = 1'b1; m_hist[i] = 1'b1;
            m_pend[i]  = 1'b0; m_ovr[i]   = 1'b0;
            m_addr[i]  = '0;   m_data[i]  = '0;
         end
         m_ptr = NREQ - 1; m_wait = 0;
         m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_wr_src = 0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            s[i]       = (SD == 2) ? m_pipe1[i] : bus.req_stb[i];
            m_pipe1[i] = m_pipe0[i];
            m_pipe0[i] = bus.req_stb[i];
         end
         m_wr_en = 1'b0;
         win     = -1;
         if (m_wait > 0) begin
            m_wait--;
         end else begin
            for (int k = 1; k <= NREQ; k++)
               if (win < 0 && m_pend[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            if (win >= 0) begin
               m_wr_en   = 1'b1;
               m_wr_addr = m_addr[win];
               m_wr_data = m_data[win];
               m_wr_src  = win;
               m_pend[win] = 1'b0;
               m_ptr  = win;
               m_wait = GAP + 1;
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (s[i] && !m_hist[i]) begin
               if (m_pend[i]) m_ovr[i] = 1'b1;
               m_pend[i] = 1'b1;
               m_addr[i] = bus.req_addr[i*AW +: AW];
               m_data[i] = bus.req_data[i*DW +: DW];
            end
            m_hist[i] = s[i];
         end
      end
   end

   int w_src [$];
   int w_addr [$];
   int w_data [$];
   int w_cyc [$];

   always @(negedge clock) begin
      logic [NREQ-1:0] pv, ov;
      if (m_live) begin
         for (int i = 0; i < NREQ; i++) begin
            pv[i] = m_pend[i];
            ov[i] = m_ovr[i];
         end
         chk("wr_en",    64'(bus.wr_en),    64'(m_wr_en));
         chk("wr_addr",  64'(bus.wr_addr),  64'(m_wr_addr));
         chk("wr_data",  64'(bus.wr_data),  64'(m_wr_data));
         chk("wr_src",   64'(bus.wr_src),   64'(m_wr_src));
         chk("busy",     64'(bus.busy),     64'(m_wait > 0));
         chk("req_pend", 64'(bus.req_pend), 64'(pv));
         chk("req_ovr",  64'(bus.req_ovr),  64'(ov));
         if (bus.wr_en) begin
            w_src.push_back(int'(bus.wr_src));
            w_addr.push_back(int'(bus.wr_addr));
            w_data.push_back(int'(bus.wr_data));
            w_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_stb[i]           = v;
      bus.req_addr[i*AW +: AW] = a;
      bus.req_data[i*DW +: DW] = d;
   endtask

   task automatic set_stb(input int i, input logic v);
      bus.req_stb[i] = v;
   endtask

   task automatic clear_log();
      w_src.delete(); w_addr.delete(); w_data.delete(); w_cyc.delete();
   endtask

   initial begin
      int t0;
      int cd [NREQ];
      bus.req_stb  = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      reset = 1'b1;
      tick(3);
      chk("rst wr_en", 64'(bus.wr_en), 64'(0));
      chk("rst busy",  64'(bus.busy), 64'(0));
      chk("rst pend",  64'(bus.req_pend), 64'(0));
      chk("rst ovr",   64'(bus.req_ovr), 64'(0));
      chk("rst src",   64'(bus.wr_src), 64'(0));
      reset = 1'b0;
      tick(2);

      // Fairness: all four rise together, pointer starts at NREQ-1
      clear_log();
      t0 = cyc;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 8), DW'(16'hA000 + i));
      tick(20);
      chk("fair count", 64'(w_src.size()), 64'(4));
      if (w_src.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("fair order", 64'(w_src[i]), 64'(i));
         chk("fair first lat", 64'(w_cyc[0] - t0), 64'(2 + SD));
         for (int i = 1; i < 4; i++) chk("fair spacing", 64'(w_cyc[i] - w_cyc[i-1]), 64'(3));
         chk("fair data3", 64'(w_data[3]), 64'(16'hA003));
      end
      chk("fair ovr", 64'(bus.req_ovr), 64'(0));
      for (int i = 0; i < NREQ; i++) set_stb(i, 1'b0);
      tick(4);

      // Single write from requester 2
      clear_log();
      t0 = cyc;
      set_req(2, 1'b1, 6'h15, 16'hBEEF);
      tick(4);
      set_stb(2, 1'b0);
      tick(8);
      chk("single count", 64'(w_src.size()), 64'(1));
      if (w_src.size() == 1) begin
         chk("single src",  64'(w_src[0]), 64'(2));
         chk("single addr", 64'(w_addr[0]), 64'(6'h15));
         chk("single data", 64'(w_data[0]), 64'(16'hBEEF));
         chk("single lat",  64'(w_cyc[0] - t0), 64'(2 + SD));
      end
      chk("single pend", 64'(bus.req_pend[2]), 64'(0));

      // Overrun: slot 1 rewritten while it waits behind 3 and 0
      clear_log();
      set_req(3, 1'b1, 6'h03, 16'h3333);
      set_req(0, 1'b1, 6'h10, 16'h0A0A);
      set_req(1, 1'b1, 6'h21, 16'h1111);
      tick(4);
      set_stb(1, 1'b0);
      tick(2);
      set_req(1, 1'b1, 6'h22, 16'h2222);
      tick(1);
      set_stb(0, 1'b0);
      set_stb(3, 1'b0);
      tick(12);
      set_stb(1, 1'b0);
      tick(3);
      chk("ovr count", 64'(w_src.size()), 64'(3));
      if (w_src.size() == 3) begin
         chk("ovr src0", 64'(w_src[0]), 64'(3));
         chk("ovr src1", 64'(w_src[1]), 64'(0));
         chk("ovr src2", 64'(w_src[2]), 64'(1));
         chk("ovr data", 64'(w_data[2]), 64'(16'h2222));
         chk("ovr addr", 64'(w_addr[2]), 64'(6'h22));
      end
      chk("ovr flags", 64'(bus.req_ovr), 64'(4'b0010));

      // Collision: slot 3 re-captured on the edge it is granted
      clear_log();
      set_req(2, 1'b1, 6'h02, 16'h2200);
      set_req(3, 1'b1, 6'h30, 16'h3AAA);
      tick(3);
      set_stb(3, 1'b0);
      tick(1);
      set_req(3, 1'b1, 6'h31, 16'h3BBB);
      tick(12);
      set_stb(2, 1'b0);
      set_stb(3, 1'b0);
      tick(3);
      chk("coll count", 64'(w_src.size()), 64'(3));
      if (w_src.size() == 3) begin
         chk("coll src0",  64'(w_src[0]), 64'(2));
         chk("coll src1",  64'(w_src[1]), 64'(3));
         chk("coll src2",  64'(w_src[2]), 64'(3));
         chk("coll old",   64'(w_data[1]), 64'(16'h3AAA));
         chk("coll new",   64'(w_data[2]), 64'(16'h3BBB));
      end
      chk("coll ovr3", 64'(bus.req_ovr[3]), 64'(0));

      // Reset in the middle of a write with strobe 0 held high
      clear_log();
      set_req(0, 1'b1, 6'h05, 16'h5555);
      tick(2 + SD);
      chk("pre-reset wr_en", 64'(bus.wr_en), 64'(1));
      reset = 1'b1;
      tick(1);
      chk("mid rst wr_en", 64'(bus.wr_en), 64'(0));
      chk("mid rst busy",  64'(bus.busy), 64'(0));
      chk("mid rst pend",  64'(bus.req_pend), 64'(0));
      chk("mid rst ovr",   64'(bus.req_ovr), 64'(0));
      chk("mid rst addr",  64'(bus.wr_addr), 64'(0));
      chk("mid rst data",  64'(bus.wr_data), 64'(0));
      reset = 1'b0;
      clear_log();
      tick(10);
      chk("held stb writes", 64'(w_src.size()), 64'(0));
      set_stb(0, 1'b0);
      tick(4);
      set_req(0, 1'b1, 6'h06, 16'h6666);
      tick(10);
      chk("re-rise count", 64'(w_src.size()), 64'(1));
      if (w_src.size() == 1) chk("re-rise data", 64'(w_data[0]), 64'(16'h6666));
      set_stb(0, 1'b0);
      tick(4);

      // Random strobes; each level held at least 4 cycles so addr/data stay stable through capture
      for (int i = 0; i < NREQ; i++) cd[i] = $urandom_range(0, 6);
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (cd[i] == 0) begin
               if (bus.req_stb[i]) set_stb(i, 1'b0);
               else set_req(i, 1'b1, AW'($urandom), DW'($urandom));
               cd[i] = $urandom_range(4, 12);
            end else begin
               cd[i]--;
            end
         end
         tick(1);
      end
      bus.req_stb = '0;
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
